frame_scanner: RTL and testbench

//  Downstream scan-out stage for the iteration framebuffer RAM (1-cycle read latency).

---
 rtl/frame_scanner.sv | 161 ++++++++++++++++
 tb/tb_frame_scanner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/frame_scanner.sv
// 640x480@60 VGA scan-out from an upscaled iteration framebuffer, mapped to 4:4:4 RGB.
// Optional palette cycling is enabled with FRAME_SCANNER_PALETTE_CYCLE_EN.
module frame_scanner #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 15,
  parameter int MAX_ITER    = 255
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic [3:0]            red_o,
  output logic [3:0]            green_o,
  output logic [3:0]            blue_o,
  output logic                  frame_done_o
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_WIDTH = H_ACTIVE >> SCALE_SHIFT;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MASK   = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] FB_W_L = ADDR_WIDTH'(FB_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAX_L  = DATA_WIDTH'(MAX_ITER);

  if (FB_WIDTH * (V_ACTIVE >> SCALE_SHIFT) > (1 << ADDR_WIDTH)) begin : g_addr_check
    $error("frame_scanner: framebuffer does not fit in ADDR_WIDTH");
  end

  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  active0_s, hsync0_s, vsync0_s, frame_done_d;
  logic                  active1_q, hsync1_q, vsync1_q;
  logic                  hsync_q, vsync_q, frame_done_q;
  logic [3:0]            red_q, green_q, blue_q, red_d, green_d, blue_d;
  logic [DATA_WIDTH-1:0] offset_s, idx_s;

  // Raster counters and row base; row_base steps once per upscaled framebuffer row.
  always_comb begin
    h_d        = h_q + HW'(1);
    v_d        = v_q;
    row_base_d = row_base_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d        = '0;
        row_base_d = '0;
      end else begin
        v_d = v_q + VW'(1);
        if ((v_q < V_ACT_L) && ((v_q & V_MASK) == V_MASK)) begin
          row_base_d = row_base_q + FB_W_L;
        end else begin
          row_base_d = row_base_q;
        end
      end
    end else begin
      v_d = v_q;
    end
  end

  assign active0_s    = (h_q < H_ACT_L) && (v_q < V_ACT_L);
  assign hsync0_s     = !((h_q >= HS_START) && (h_q < HS_END));
  assign vsync0_s     = !((v_q >= VS_START) && (v_q < VS_END));
  assign frame_done_d = (h_d == '0) && (v_d == V_ACT_L);
  assign rd_addr_o    = active0_s ? (row_base_q + ADDR_WIDTH'(h_q >> SCALE_SHIFT)) : '0;

`ifdef FRAME_SCANNER_PALETTE_CYCLE_EN
  logic [DATA_WIDTH-1:0] offset_q;

  // Palette offset advances once per frame, at the start of vblank.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      offset_q <= '0;
    end else if (frame_done_q) begin
      offset_q <= offset_q + DATA_WIDTH'(1);
    end
  end

  assign offset_s = offset_q;
`else
  assign offset_s = '0;
`endif

  // Colour mapping; the in-set test uses the raw count, not the offset index.
  always_comb begin
    idx_s   = rd_data_i + offset_s;
    red_d   = 4'd0;
    green_d = 4'd0;
    blue_d  = 4'd0;
    if (active1_q && (rd_data_i != MAX_L)) begin
      red_d   = idx_s[3:0];
      green_d = {idx_s[1:0], idx_s[3:2]};
      blue_d  = ~idx_s[3:0];
    end else begin
      red_d   = 4'd0;
      green_d = 4'd0;
      blue_d  = 4'd0;
    end
  end

  // All pipeline and output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      h_q          <= '0;
      v_q          <= '0;
      row_base_q   <= '0;
      active1_q    <= 1'b0;
      hsync1_q     <= 1'b1;
      vsync1_q     <= 1'b1;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      red_q        <= 4'd0;
      green_q      <= 4'd0;
      blue_q       <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      row_base_q   <= row_base_d;
      active1_q    <= active0_s;
      hsync1_q     <= hsync0_s;
      vsync1_q     <= vsync0_s;
      hsync_q      <= hsync1_q;
      vsync_q      <= vsync1_q;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign red_o        = red_q;
  assign green_o      = green_q;
  assign blue_o       = blue_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_frame_scanner.sv
// Directed bench for frame_scanner; vertical timing shortened so full frames fit the run.
module tb_frame_scanner;

  localparam int V_ACT = 16;
  localparam int LINE  = 800;
  localparam int FRAME = LINE * (V_ACT + 2 + 2 + 2);
`ifdef FRAME_SCANNER_PALETTE_CYCLE_EN
  localparam int F1_RED = 7;
`else
  localparam int F1_RED = 6;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic [7:0]  ram_val = 8'h06;
  logic        hsync, vsync, frame_done;
  logic [3:0]  red, green, blue;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  frame_scanner #(
    .V_ACTIVE(V_ACT), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clock_i(clk), .reset_i(reset), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .hsync_o(hsync), .vsync_o(vsync), .red_o(red), .green_o(green), .blue_o(blue),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= ram_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_rgb(input string tag, input int r, input int g, input int b);
    chk({tag, "_red"}, 32'(red), 32'(r));
    chk({tag, "_green"}, 32'(green), 32'(g));
    chk({tag, "_blue"}, 32'(blue), 32'(b));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk_rgb("rst", 0, 0, 0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);

    reset = 1'b0;
    cyc = 0;
    chk("c0_rd_addr", 32'(rd_addr), 32'd0);
    run_to(1);
    chk_rgb("c1_unfilled", 0, 0, 0);
    run_to(2);
    chk_rgb("pix00", 6, 9, 9);
    run_to(13);
    chk("addr_v0h13", 32'(rd_addr), 32'd3);
    run_to(639);
    chk("addr_v0h639", 32'(rd_addr), 32'd159);
    run_to(640);
    chk("addr_hblank", 32'(rd_addr), 32'd0);
    run_to(641);
    chk("last_pix_red", 32'(red), 32'd6);
    run_to(642);
    chk_rgb("hblank", 0, 0, 0);
    run_to(657);
    chk("hsync_657", 32'(hsync), 32'd1);
    run_to(658);
    chk("hsync_658", 32'(hsync), 32'd0);
    run_to(753);
    chk("hsync_753", 32'(hsync), 32'd0);
    run_to(754);
    chk("hsync_754", 32'(hsync), 32'd1);
    run_to(LINE + 657);
    chk("hsync_l1_657", 32'(hsync), 32'd1);
    run_to(LINE + 658);
    chk("hsync_l1_658", 32'(hsync), 32'd0);

    run_to(5 * LINE + 13);
    chk("addr_v5h13", 32'(rd_addr), 32'd163);
    run_to(5 * LINE + 100);
    ram_val = 8'd255;
    run_to(5 * LINE + 102);
    chk_rgb("max_iter", 0, 0, 0);
    ram_val = 8'h06;
    run_to(5 * LINE + 104);
    chk_rgb("after_max", 6, 9, 9);
    run_to(5 * LINE + 200);
    ram_val = 8'h3C;
    run_to(5 * LINE + 202);
    chk_rgb("pat_3c", 12, 3, 3);
    ram_val = 8'h06;

    run_to(15 * LINE + 639);
    chk("addr_last", 32'(rd_addr), 32'd639);
    run_to(V_ACT * LINE - 1);
    chk("fd_before", 32'(frame_done), 32'd0);
    run_to(V_ACT * LINE);
    chk("fd_pulse", 32'(frame_done), 32'd1);
    chk("addr_vblank", 32'(rd_addr), 32'd0);
    run_to(V_ACT * LINE + 1);
    chk("fd_after", 32'(frame_done), 32'd0);
    run_to(18 * LINE + 1);
    chk("vsync_before", 32'(vsync), 32'd1);
    run_to(18 * LINE + 2);
    chk("vsync_start", 32'(vsync), 32'd0);
    run_to(20 * LINE + 1);
    chk("vsync_end", 32'(vsync), 32'd0);
    run_to(20 * LINE + 2);
    chk("vsync_release", 32'(vsync), 32'd1);

    run_to(FRAME + 1);
    chk("f1_addr_h1", 32'(rd_addr), 32'd0);
    run_to(FRAME + 2);
    chk("f1_pix00_red", 32'(red), 32'(F1_RED));
    run_to(FRAME + V_ACT * LINE - 1);
    chk("fd2_before", 32'(frame_done), 32'd0);
    run_to(FRAME + V_ACT * LINE);
    chk("fd2_pulse", 32'(frame_done), 32'd1);

    run_to(2 * FRAME + 10 * LINE + 300);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    chk("mr_rd_addr", 32'(rd_addr), 32'd0);
    chk_rgb("mr_c0", 0, 0, 0);
    chk("mr_hsync0", 32'(hsync), 32'd1);
    chk("mr_vsync0", 32'(vsync), 32'd1);
    run_to(1);
    chk_rgb("mr_c1", 0, 0, 0);
    chk("mr_hsync1", 32'(hsync), 32'd1);
    run_to(2);
    chk_rgb("mr_pix00", 6, 9, 9);
    run_to(13);
    chk("mr_addr_h13", 32'(rd_addr), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
